// File: rtl/key_expander_pkg.sv
// Shared AES-128 key-schedule types, Rcon lookup, FSM states and the byte S-box table.
package key_expander_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    typedef enum logic {IDLE, EMIT} state_e;

    // Indexed by target round; entries past NUM_ROUNDS are padding so a 4-bit index never leaves the table.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    // Entry 0 sits in the top byte, so byte b starts at bit 8*(255-b) = {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/key_expander_sub_word.sv
// 32-bit SubWord: four byte S-boxes sharing the round datapath's substitution table.
module aes_sbox
    import key_expander_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    assign byte_o = sbox(byte_i);
endmodule

module sub_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.byte_i(word_i[8*i +: 8]), .byte_o(word_o[8*i +: 8]));
    end
endmodule

// File: rtl/key_expander.sv
// Sequential AES-128 key schedule emitting round keys over valid/ready, one key held at a time.
// Define KEY_CACHE_EN to add a round-key store with replay and reverse-order (decryption) emission.
module key_expander #(
    parameter int NUM_ROUNDS = key_expander_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipherKey,
    input  logic         keyReady,
`ifdef KEY_CACHE_EN
    input  logic         replay,
    input  logic         reverseOrder,
`endif
    output logic         keyValid,
    output logic [127:0] roundKey,
    output logic [3:0]   roundIndex,
    output logic         busy,
    output logic         done
);
    import key_expander_pkg::*;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_e     state_q;
    key_t       key_q, key_d, next_key;
    logic [3:0] round_q, round_d, rcon_idx;
    logic       busy_q, done_q, last;
    word_t      w0, w1, w2, w3, sw, t, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_q;

    sub_word u_sub_word (.word_i({w3[23:0], w3[31:24]}), .word_o(sw));

    assign rcon_idx = (round_q == LAST) ? 4'd0 : round_q + 4'd1;
    assign t        = sw ^ {RCON[rcon_idx], 24'h0};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

`ifdef KEY_CACHE_EN
    key_t       cache_q [0:NUM_ROUNDS];
    logic       cvalid_q, replay_q, rev_q;
    logic [3:0] step;

    assign step    = rev_q ? round_q - 4'd1 : round_q + 4'd1;
    assign last    = rev_q ? (round_q == 4'd0) : (round_q == LAST);
    assign key_d   = replay_q ? cache_q[step] : next_key;
    assign round_d = step;

    // Store is plain storage; validity is tracked by cvalid_q, which reset clears.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start)
            cache_q[0] <= cipherKey;
        else if (state_q == EMIT && keyReady && !last && !replay_q)
            cache_q[step] <= next_key;
    end
`else
    assign last    = (round_q == LAST);
    assign key_d   = next_key;
    assign round_d = round_q + 4'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            round_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef KEY_CACHE_EN
            cvalid_q <= 1'b0;
            replay_q <= 1'b0;
            rev_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= EMIT;
                        key_q    <= cipherKey;
                        round_q  <= '0;
                        busy_q   <= 1'b1;
`ifdef KEY_CACHE_EN
                        cvalid_q <= 1'b0;
                        replay_q <= 1'b0;
                        rev_q    <= 1'b0;
                    end else if (replay && cvalid_q) begin
                        state_q  <= EMIT;
                        key_q    <= reverseOrder ? cache_q[LAST] : cache_q[0];
                        round_q  <= reverseOrder ? LAST : 4'd0;
                        busy_q   <= 1'b1;
                        replay_q <= 1'b1;
                        rev_q    <= reverseOrder;
`endif
                    end
                end
                EMIT: begin
                    if (keyReady) begin
                        if (last) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
`ifdef KEY_CACHE_EN
                            cvalid_q <= 1'b1;
`endif
                        end else begin
                            key_q   <= key_d;
                            round_q <= round_d;
                        end
                    end
                end
            endcase
        end
    end

    assign keyValid   = (state_q == EMIT);
    assign roundKey   = key_q;
    assign roundIndex = round_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander: reference key schedule model feeding a scoreboard queue.
module tb_key_expander;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         keyReady = 1'b0;
    logic [127:0] cipherKey = '0;
`ifdef KEY_CACHE_EN
    logic         replay = 1'b0;
    logic         reverseOrder = 1'b0;
`endif
    logic         keyValid, busy, done;
    logic [127:0] roundKey;
    logic [3:0]   roundIndex;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1F  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10F = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZKEY = 128'h0;
    localparam logic [127:0] R1Z  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] R10Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expander dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cipherKey(cipherKey),
        .keyReady(keyReady),
`ifdef KEY_CACHE_EN
        .replay(replay), .reverseOrder(reverseOrder),
`endif
        .keyValid(keyValid), .roundKey(roundKey), .roundIndex(roundIndex),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: S-box from GF(2^8) inverse plus affine map, Rcon by repeated doubling.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gm(inv, a);
        return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] nk(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = xt(rc);
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic push_exp(input logic [127:0] k, input bit rev);
        logic [127:0] ks [11];
        ks[0] = k;
        for (int r = 1; r <= 10; r++) ks[r] = nk(ks[r-1], r);
        for (int i = 0; i < 11; i++) begin
            int j;
            j = rev ? 10 - i : i;
            sb_q.push_back({4'(j), ks[j]});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        keyReady = 1'b1;
        #12;
        checks++; if (keyValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", keyValid); end
        checks++; if (roundKey !== '0) begin errors++; $display("FAIL reset_key got %h exp 0", roundKey); end
        checks++; if (roundIndex !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", roundIndex); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        exp_t e;
        int   cyc, dcyc;
        sb_q.delete();
        push_exp(FIPS, 1'b0);
        @(posedge clk); #1;
        cipherKey = FIPS; start = 1'b1; keyReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; dcyc = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fips_busy got %b exp 1", busy); end
        while (dcyc == 0 && cyc < 40) begin
            if (keyValid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL fips_extra got idx %0d exp none", roundIndex);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({roundIndex, roundKey} !== e) begin
                        errors++; $display("FAIL fips_seq got %0d/%h exp %0d/%h", roundIndex, roundKey, e.idx, e.key);
                    end
                    if (e.idx == 4'd1) begin
                        checks++; if (roundKey !== R1F) begin errors++; $display("FAIL fips_r1 got %h exp %h", roundKey, R1F); end
                    end
                    if (e.idx == 4'd10) begin
                        checks++; if (roundKey !== R10F) begin errors++; $display("FAIL fips_r10 got %h exp %h", roundKey, R10F); end
                    end
                end
            end
            if (done) dcyc = cyc;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (dcyc != 12) begin errors++; $display("FAIL fips_done_cycle got %0d exp 12", dcyc); end
        checks++; if (busy !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL fips_end got busy %b left %0d exp 0 0", busy, sb_q.size()); end
    endtask

    task automatic test_toggle();
        exp_t e;
        int   cyc, dcyc;
        bit   held;
        logic [131:0] prev;
        sb_q.delete();
        push_exp(FIPS, 1'b0);
        @(posedge clk); #1;
        cipherKey = FIPS; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; dcyc = 0; held = 1'b0; prev = '0;
        while (dcyc == 0 && cyc < 60) begin
            keyReady = (cyc % 2 == 1);
            if (held) begin
                checks++;
                if ({roundIndex, roundKey} !== prev) begin
                    errors++; $display("FAIL toggle_hold got %0d/%h exp %0d/%h", roundIndex, roundKey, prev[131:128], prev[127:0]);
                end
            end
            if (keyValid && keyReady) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL toggle_extra got idx %0d exp none", roundIndex);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({roundIndex, roundKey} !== e) begin
                        errors++; $display("FAIL toggle_seq got %0d/%h exp %0d/%h", roundIndex, roundKey, e.idx, e.key);
                    end
                end
            end
            held = keyValid && !keyReady;
            prev = {roundIndex, roundKey};
            if (done) dcyc = cyc;
            else begin @(posedge clk); #1; cyc++; end
        end
        keyReady = 1'b1;
        checks++; if (dcyc != 22 || sb_q.size() != 0) begin errors++; $display("FAIL toggle_done got cycle %0d left %0d exp 22 0", dcyc, sb_q.size()); end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   cyc, dcyc;
        sb_q.delete();
        push_exp(FIPS, 1'b0);
        @(posedge clk); #1;
        cipherKey = FIPS; start = 1'b1; keyReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; dcyc = 0;
        while (dcyc == 0 && cyc < 40) begin
            start = 1'b0;
            if (keyValid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL ign_extra got idx %0d exp none", roundIndex);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({roundIndex, roundKey} !== e) begin
                        errors++; $display("FAIL ign_seq got %0d/%h exp %0d/%h", roundIndex, roundKey, e.idx, e.key);
                    end
                    if (e.idx == 4'd5) begin
                        start = 1'b1; cipherKey = ZKEY;
                    end
                end
            end
            if (done) dcyc = cyc;
            else begin @(posedge clk); #1; cyc++; end
        end
        start = 1'b0;
        checks++; if (dcyc != 12 || sb_q.size() != 0) begin errors++; $display("FAIL ign_done got cycle %0d left %0d exp 12 0", dcyc, sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc, nd, d1, d2;
        sb_q.delete();
        push_exp(FIPS, 1'b0);
        @(posedge clk); #1;
        cipherKey = FIPS; start = 1'b1; keyReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; nd = 0; d1 = 0; d2 = 0;
        while (nd < 2 && cyc < 60) begin
            if (keyValid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra got idx %0d exp none", roundIndex);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({roundIndex, roundKey} !== e) begin
                        errors++; $display("FAIL b2b_seq got %0d/%h exp %0d/%h", roundIndex, roundKey, e.idx, e.key);
                    end
                end
            end
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d1 = cyc; start = 1'b1; cipherKey = ZKEY;
                    push_exp(ZKEY, 1'b0);
                end else d2 = cyc;
            end
            if (nd < 2) begin @(posedge clk); #1; cyc++; start = 1'b0; end
        end
        checks++; if (d1 != 12 || d2 != 24) begin errors++; $display("FAIL b2b_done got %0d,%0d exp 12,24", d1, d2); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d exp 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc, dcyc;
        @(posedge clk); #1;
        cipherKey = FIPS; start = 1'b1; keyReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!(keyValid && roundIndex == 4'd3) && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++; if (roundIndex !== 4'd3) begin errors++; $display("FAIL rmid_reach got %0d exp 3", roundIndex); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (keyValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl got v%b b%b d%b exp 000", keyValid, busy, done);
        end
        checks++; if (roundKey !== '0 || roundIndex !== 4'd0) begin
            errors++; $display("FAIL rmid_data got %0d/%h exp 0/0", roundIndex, roundKey);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        push_exp(ZKEY, 1'b0);
        @(posedge clk); #1;
        cipherKey = ZKEY; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; dcyc = 0;
        while (dcyc == 0 && cyc < 40) begin
            if (keyValid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL zero_extra got idx %0d exp none", roundIndex);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({roundIndex, roundKey} !== e) begin
                        errors++; $display("FAIL zero_seq got %0d/%h exp %0d/%h", roundIndex, roundKey, e.idx, e.key);
                    end
                    if (e.idx == 4'd1) begin
                        checks++; if (roundKey !== R1Z) begin errors++; $display("FAIL zero_r1 got %h exp %h", roundKey, R1Z); end
                    end
                    if (e.idx == 4'd10) begin
                        checks++; if (roundKey !== R10Z) begin errors++; $display("FAIL zero_r10 got %h exp %h", roundKey, R10Z); end
                    end
                end
            end
            if (done) dcyc = cyc;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++; if (dcyc != 12 || sb_q.size() != 0) begin errors++; $display("FAIL zero_done got cycle %0d left %0d exp 12 0", dcyc, sb_q.size()); end
    endtask

`ifdef KEY_CACHE_EN
    task automatic test_cache_cold();
        @(posedge clk); #1;
        replay = 1'b1; reverseOrder = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        checks++; if (keyValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL cold_replay got v%b b%b exp 00", keyValid, busy);
        end
        @(posedge clk); #1;
        checks++; if (keyValid !== 1'b0) begin errors++; $display("FAIL cold_replay2 got %b exp 0", keyValid); end
    endtask

    task automatic test_cache_replay();
        exp_t e;
        int   cyc, dcyc, n;
        sb_q.delete();
        push_exp(FIPS, 1'b1);
        @(posedge clk); #1;
        replay = 1'b1; reverseOrder = 1'b1; keyReady = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0; cyc = 1; dcyc = 0; n = 0;
        checks++; if ({roundIndex, roundKey} !== {4'd10, R10F}) begin
            errors++; $display("FAIL rev_first got %0d/%h exp 10/%h", roundIndex, roundKey, R10F);
        end
        while (dcyc == 0 && cyc < 40) begin
            if (keyValid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rev_extra got idx %0d exp none", roundIndex);
                end else begin
                    e = sb_q.pop_front();
                    n++;
                    checks++;
                    if ({roundIndex, roundKey} !== e) begin
                        errors++; $display("FAIL rev_seq got %0d/%h exp %0d/%h", roundIndex, roundKey, e.idx, e.key);
                    end
                    if (n == 11) begin
                        checks++; if ({roundIndex, roundKey} !== {4'd0, FIPS}) begin
                            errors++; $display("FAIL rev_last got %0d/%h exp 0/%h", roundIndex, roundKey, FIPS);
                        end
                    end
                end
            end
            if (done) dcyc = cyc;
            else begin @(posedge clk); #1; cyc++; end
        end
        reverseOrder = 1'b0;
        checks++; if (dcyc != 12 || n != 11) begin errors++; $display("FAIL rev_done got cycle %0d keys %0d exp 12 11", dcyc, n); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef KEY_CACHE_EN
        test_cache_cold();
`endif
        test_fips();
`ifdef KEY_CACHE_EN
        test_cache_replay();
`endif
        test_toggle();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
